// File: rtl/shift_req_sequencer.sv
// rtl/shift_req_sequencer.sv - round-robin sequencer sharing one 4-bit barrel shifter between two requesters
//
// Accepts one shift request at a time from two requesters (round-robin), splits
// amounts larger than 3 into passes of at most 3 through the external shifter
// (one pass per clock, partial result fed back), then returns the result with
// the requester id on a valid/ready response channel.
//
// Optional build macro: SHIFT_SEQ_EARLY_ZERO_EN
//   When defined, any accepted amount >= 4 yields a zero result directly and
//   skips the shifter passes entirely.
//
// Ports:
//   clk, rst_n                         clock (rising edge), async active-low reset
//   req0_valid/ready/din/amt           requester 0 request channel
//   req1_valid/ready/din/amt           requester 1 request channel
//   rsp_valid/ready, rsp_dout, rsp_id  response channel (data + requester id)
//   sh_din, sh_sel, sh_dout            shared shifter: sh_dout = sh_din << sh_sel
//   busy                               high whenever not idle

module shift_req_sequencer #(
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_din,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_din,
    input  logic [AMT_W-1:0] req1_amt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_dout,
    output logic             rsp_id,
    output logic [3:0]       sh_din,
    output logic [1:0]       sh_sel,
    input  logic [3:0]       sh_dout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [3:0]       acc;
    logic [AMT_W-1:0] rem;
    logic             id;
    logic             last_grant;
    logic [3:0]       rsp_dout_q;
    logic             rsp_id_q;

    logic             gnt0;
    logic             gnt1;
    logic             accept;
    logic [3:0]       gnt_din;
    logic [AMT_W-1:0] gnt_amt;
    logic             gnt_direct;
    logic             early_zero;
    logic [1:0]       pass_sel;
    logic [AMT_W-1:0] rem_nxt;
    logic             last_pass;

    // Round-robin: a lone requester always wins; on contention the one that
    // did not win last time wins.
    always_comb begin
        gnt0    = req0_valid & (~req1_valid | last_grant);
        gnt1    = req1_valid & (~req0_valid | ~last_grant);
        accept  = (state == IDLE) & (gnt0 | gnt1);
        gnt_din = gnt1 ? req1_din : req0_din;
        gnt_amt = gnt1 ? req1_amt : req0_amt;
    end

`ifdef SHIFT_SEQ_EARLY_ZERO_EN
    // Anything shifted by 4 or more out of a 4-bit word is zero.
    assign early_zero = (gnt_amt > AMT_W'(3));
`else
    assign early_zero = 1'b0;
`endif

    // Requests that need no shifter pass go straight to the response state.
    assign gnt_direct = (gnt_amt == '0) | early_zero;

    // Largest pass the 2-bit select allows; sel <= rem so rem cannot underflow.
    always_comb begin
        pass_sel  = (rem > AMT_W'(3)) ? 2'd3 : rem[1:0];
        rem_nxt   = rem - AMT_W'(pass_sel);
        last_pass = (rem_nxt == '0);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = gnt_direct ? RESP : SHIFT;
                end
            end
            SHIFT: begin
                if (last_pass) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs. Ready is masked by reset so nothing looks accepted while held.
    always_comb begin
        req0_ready = rst_n & (state == IDLE) & gnt0;
        req1_ready = rst_n & (state == IDLE) & gnt1;
        sh_din     = acc;
        sh_sel     = (state == SHIFT) ? pass_sel : 2'd0;
        rsp_valid  = (state == RESP);
        busy       = (state != IDLE);
        rsp_dout   = rsp_dout_q;
        rsp_id     = rsp_id_q;
    end

    // Datapath. The response registers load only on entry to RESP so they
    // keep showing the previous result while a new request is being shifted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= 4'd0;
            rem        <= '0;
            id         <= 1'b0;
            last_grant <= 1'b1;
            rsp_dout_q <= 4'd0;
            rsp_id_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc        <= early_zero ? 4'd0 : gnt_din;
                        rem        <= gnt_amt;
                        id         <= gnt1;
                        last_grant <= gnt1;
                        if (gnt_direct) begin
                            rsp_dout_q <= early_zero ? 4'd0 : gnt_din;
                            rsp_id_q   <= gnt1;
                        end
                    end
                end
                SHIFT: begin
                    acc <= sh_dout;
                    rem <= rem_nxt;
                    if (last_pass) begin
                        rsp_dout_q <= sh_dout;
                        rsp_id_q   <= id;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_req_sequencer.sv
// tb/tb_shift_req_sequencer.sv - self-checking bench for shift_req_sequencer
module tb_shift_req_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [3:0] req0_din = 4'd0;
    logic [3:0] req0_amt = 4'd0;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [3:0] req1_din = 4'd0;
    logic [3:0] req1_amt = 4'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_dout;
    logic       rsp_id;
    logic [3:0] sh_din;
    logic [1:0] sh_sel;
    logic [3:0] sh_dout;
    logic       busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    bit         model_last = 1'b1;
    logic [3:0] obs_dout;
    logic       obs_id;
    int         obs_lat;

    shift_req_sequencer #(.AMT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_din   (req0_din),
        .req0_amt   (req0_amt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_din   (req1_din),
        .req1_amt   (req1_amt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_dout   (rsp_dout),
        .rsp_id     (rsp_id),
        .sh_din     (sh_din),
        .sh_sel     (sh_sel),
        .sh_dout    (sh_dout),
        .busy       (busy)
    );

    // External shared shifter.
    assign sh_dout = 4'(sh_din << sh_sel);

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One request/response exchange, checked against a reference computed
    // from the whole-shift result and the pass-splitting rule.
    task automatic serve(input logic v0, input logic v1,
                         input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] a0, input logic [3:0] a1,
                         input int stall);
        logic       g;
        logic [3:0] din;
        logic [3:0] a;
        logic [3:0] exp_res;
        int         amt;
        int         r;
        int         s;
        int         c;
        int         exp_lat;
        int         q_sel[$];
        logic [3:0] q_din[$];
        bit         seq_ok;
        bit         rdy_ok;
        bit         stable_ok;

        req0_valid = v0; req0_din = d0; req0_amt = a0;
        req1_valid = v1; req1_din = d1; req1_amt = a1;
        rsp_ready  = (stall == 0);
        #1;
        g = (v0 && v1) ? ~model_last : v1;
        total_cnt++;
        if (req0_ready !== (v0 && !g) || req1_ready !== (v1 && g))
            $display("FAIL grant_ready: got r0=%b r1=%b, want r0=%b r1=%b",
                     req0_ready, req1_ready, v0 && !g, v1 && g);
        else pass_cnt++;

        din     = g ? d1 : d0;
        amt     = int'(g ? a1 : a0);
        exp_res = 4'(din << amt);
        exp_lat = 1 + (amt + 2) / 3;
        r = amt;
        a = din;
        while (r > 0) begin
            s = (r > 3) ? 3 : r;
            q_sel.push_back(s);
            q_din.push_back(a);
            a = 4'(a << s);
            r -= s;
        end
`ifdef SHIFT_SEQ_EARLY_ZERO_EN
        if (amt >= 4) begin
            exp_res = 4'd0;
            exp_lat = 1;
            q_sel.delete();
            q_din.delete();
        end
`endif

        tick;
        model_last = g;
        if (g) req1_valid = 1'b0; else req0_valid = 1'b0;

        c = 1;
        seq_ok = 1'b1;
        rdy_ok = 1'b1;
        while (!rsp_valid && c < 40) begin
            if (c - 1 < q_sel.size()) begin
                if (int'(sh_sel) != q_sel[c-1] || sh_din !== q_din[c-1]) seq_ok = 1'b0;
            end else begin
                seq_ok = 1'b0;
            end
            if (req0_ready || req1_ready || !busy) rdy_ok = 1'b0;
            tick;
            c++;
        end
        if (req0_ready || req1_ready || !busy || sh_sel != 2'd0) rdy_ok = 1'b0;

        obs_dout = rsp_dout;
        obs_id   = rsp_id;
        obs_lat  = c;

        total_cnt++;
        if (c != exp_lat) $display("FAIL latency: got %0d cycles, want %0d (amt=%0d)", c, exp_lat, amt);
        else pass_cnt++;
        total_cnt++;
        if (!seq_ok) $display("FAIL shift_passes: pass sequence differs for din=%b amt=%0d", din, amt);
        else pass_cnt++;
        total_cnt++;
        if (rsp_dout !== exp_res) $display("FAIL rsp_dout: got %b, want %b", rsp_dout, exp_res);
        else pass_cnt++;
        total_cnt++;
        if (rsp_id !== g) $display("FAIL rsp_id: got %b, want %b", rsp_id, g);
        else pass_cnt++;
        total_cnt++;
        if (!rdy_ok) $display("FAIL busy_no_ready: ready raised or busy low while in flight");
        else pass_cnt++;

        stable_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            if (!rsp_valid || rsp_dout !== exp_res || rsp_id !== g ||
                req0_ready || req1_ready || !busy || sh_sel != 2'd0) stable_ok = 1'b0;
            tick;
        end
        if (stall > 0) begin
            total_cnt++;
            if (!stable_ok || !rsp_valid) $display("FAIL stall_stable: response changed while stalled, valid=%b", rsp_valid);
            else pass_cnt++;
        end
        rsp_ready = 1'b1;
        tick;
        total_cnt++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_dout !== exp_res)
            $display("FAIL return_idle: got busy=%b valid=%b dout=%b, want 0 0 %b", busy, rsp_valid, rsp_dout, exp_res);
        else pass_cnt++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        #2;
        total_cnt++;
        if (rsp_valid !== 1'b0 || rsp_dout !== 4'd0 || rsp_id !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_rsp: got valid=%b dout=%b id=%b busy=%b, want all 0", rsp_valid, rsp_dout, rsp_id, busy);
        else pass_cnt++;
        total_cnt++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || sh_din !== 4'd0 || sh_sel !== 2'd0)
            $display("FAIL reset_ctrl: got r0=%b r1=%b sh_din=%b sh_sel=%b, want all 0", req0_ready, req1_ready, sh_din, sh_sel);
        else pass_cnt++;
        req0_valid = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        model_last = 1'b1;
        tick;
    endtask

    task automatic test_arbitration;
        serve(1'b1, 1'b1, 4'b0001, 4'b0011, 4'd3, 4'd2, 0);
        total_cnt++;
        if (obs_dout !== 4'b1000 || obs_id !== 1'b0)
            $display("FAIL arb_first: got dout=%b id=%b, want 1000 0", obs_dout, obs_id);
        else pass_cnt++;
        serve(1'b1, 1'b1, 4'b0001, 4'b0011, 4'd3, 4'd2, 0);
        total_cnt++;
        if (obs_dout !== 4'b1100 || obs_id !== 1'b1)
            $display("FAIL arb_second: got dout=%b id=%b, want 1100 1", obs_dout, obs_id);
        else pass_cnt++;
        serve(1'b1, 1'b0, 4'b0001, 4'b0000, 4'd3, 4'd0, 0);
        total_cnt++;
        if (obs_id !== 1'b0) $display("FAIL arb_third: got id=%b, want 0", obs_id);
        else pass_cnt++;
    endtask

    task automatic test_directed;
        serve(1'b1, 1'b0, 4'b1001, 4'd0, 4'd1, 4'd0, 0);
        total_cnt++;
        if (obs_dout !== 4'b0010 || obs_id !== 1'b0 || obs_lat != 2)
            $display("FAIL amt1: got dout=%b id=%b lat=%0d, want 0010 0 2", obs_dout, obs_id, obs_lat);
        else pass_cnt++;
        serve(1'b0, 1'b1, 4'd0, 4'b0001, 4'd0, 4'd5, 0);
        total_cnt++;
        if (obs_dout !== 4'b0000 || obs_id !== 1'b1)
            $display("FAIL amt5: got dout=%b id=%b, want 0000 1", obs_dout, obs_id);
        else pass_cnt++;
        serve(1'b1, 1'b0, 4'b0110, 4'd0, 4'd0, 4'd0, 0);
        total_cnt++;
        if (obs_dout !== 4'b0110 || obs_lat != 1)
            $display("FAIL amt0: got dout=%b lat=%0d, want 0110 1", obs_dout, obs_lat);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        serve(1'b1, 1'b0, 4'b1011, 4'd0, 4'd2, 4'd0, 5);
        total_cnt++;
        if (obs_dout !== 4'b1100) $display("FAIL bp_dout: got %b, want 1100", obs_dout);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        bit quiet;
        req0_valid = 1'b1; req0_din = 4'b1111; req0_amt = 4'd15;
        #1;
        tick;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        tick;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b0 || rsp_dout !== 4'd0 || rsp_id !== 1'b0 || busy !== 1'b0 ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0 || sh_din !== 4'd0 || sh_sel !== 2'd0)
            $display("FAIL reset_mid: got valid=%b dout=%b id=%b busy=%b r1=%b sh_din=%b sh_sel=%b, want all 0",
                     rsp_valid, rsp_dout, rsp_id, busy, req1_ready, sh_din, sh_sel);
        else pass_cnt++;
        tick;
        req1_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        model_last = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid || busy) quiet = 1'b0;
            tick;
        end
        total_cnt++;
        if (!quiet) $display("FAIL reset_no_rsp: response or busy seen after reset, want none");
        else pass_cnt++;
        serve(1'b1, 1'b1, 4'b0101, 4'b0011, 4'd1, 4'd1, 0);
        total_cnt++;
        if (obs_id !== 1'b0) $display("FAIL reset_first_grant: got id=%b, want 0", obs_id);
        else pass_cnt++;
    endtask

    task automatic test_random;
        int sel;
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(1, 3);
            serve(sel[0], sel[1], 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset;
        test_arbitration;
        test_directed;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
